// File: rtl/neuromorphic_tile_ctrl.sv
// Wishbone slave that sequences single-cell READ/SET/RESET operations onto a bank
// of ReRAM crossbar tiles, with optional program-verify retry and ack timeout.
module neuromorphic_tile_ctrl #(
   parameter int          NUM_TILES = 4,
   parameter int          ROWS      = 32,
   parameter int          COLS      = 32,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          MAX_RETRY = 3,
   parameter int          TIMEOUT   = 1023,
   parameter int          VTH       = 128
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      wbs_cyc_i,
   input  logic                      wbs_stb_i,
   input  logic                      wbs_we_i,
   input  logic [3:0]                wbs_sel_i,
   input  logic [31:0]               wbs_adr_i,
   input  logic [31:0]               wbs_dat_i,
   output logic [31:0]               wbs_dat_o,
   output logic                      wbs_ack_o,
   output logic                      irq_o,
   output logic [NUM_TILES-1:0]      tile_req_o,
   output logic [1:0]                tile_op_o,
   output logic [$clog2(ROWS)-1:0]   tile_row_o,
   output logic [$clog2(COLS)-1:0]   tile_col_o,
   input  logic [NUM_TILES-1:0]      tile_ack_i,
   input  logic [NUM_TILES*8-1:0]    tile_rdata_i
);

   localparam int             RW          = $clog2(ROWS);
   localparam int             CW          = $clog2(COLS);
   localparam int             TW          = $clog2(TIMEOUT + 1) + 1;
   localparam logic [TW-1:0]  TIMEOUT_C   = TW'(TIMEOUT);
   localparam logic [3:0]     MAX_RETRY_C = 4'(MAX_RETRY);
   localparam logic [7:0]     VTH_C       = 8'(VTH);
   localparam logic [4:0]     NT_C        = 5'(NUM_TILES);
   localparam logic [1:0]     OP_READ     = 2'b00;
   localparam logic [1:0]     OP_SET      = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_VERIFY,
      S_VWAIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            ack_q, ack_d;
   logic [31:0]     dat_q, dat_d;
   logic [1:0]      ctrl_op_q, ctrl_op_d;
   logic            ctrl_ver_q, ctrl_ver_d;
   logic [CW-1:0]   addr_col_q, addr_col_d;
   logic [RW-1:0]   addr_row_q, addr_row_d;
   logic [3:0]      addr_tile_q, addr_tile_d;
   logic            irq_en_q, irq_en_d;
   logic            done_q, done_d;
   logic            err_to_q, err_to_d;
   logic            err_ver_q, err_ver_d;
   logic [3:0]      retries_q, retries_d;
   logic [7:0]      rdata_q, rdata_d;
   logic [1:0]      act_op_q, act_op_d;
   logic            act_ver_q, act_ver_d;
   logic [RW-1:0]   act_row_q, act_row_d;
   logic [CW-1:0]   act_col_q, act_col_d;
   logic [3:0]      act_tile_q, act_tile_d;
   logic [TW-1:0]   timer_q, timer_d;

   logic            wb_take;
   logic            wr_en;
   logic [5:0]      reg_idx;
   logic            busy;
   logic            start;
   logic [31:0]     rd_data;
   logic            sel_ack;
   logic [7:0]      sel_code;
   logic            verify_pass;
   logic            unused_bits;

   assign unused_bits = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

   // A held strobe is acked every other cycle so each ack stays a single-cycle pulse.
   assign wb_take = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
   assign wr_en   = wb_take & wbs_we_i & wbs_sel_i[0];
   assign reg_idx = wbs_adr_i[7:2];
   assign busy    = (state_q != S_IDLE);
   assign start   = wr_en && (reg_idx == 6'd0) && wbs_dat_i[2] && !busy;

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign irq_o      = done_q & irq_en_q;
   assign tile_row_o = act_row_q;
   assign tile_col_o = act_col_q;
   assign tile_op_o  = (state_q == S_VERIFY || state_q == S_VWAIT) ? OP_READ : act_op_q;

   always_comb begin
      rd_data = '0;
      case (reg_idx)
         6'd0: rd_data[3:0] = {ctrl_ver_q, 1'b0, ctrl_op_q};
         6'd1: begin
            rd_data[CW-1:0]  = addr_col_q;
            rd_data[8 +: RW] = addr_row_q;
            rd_data[27:24]   = addr_tile_q;
         end
         6'd2: rd_data[7:0] = {retries_q, err_ver_q, err_to_q, done_q, busy};
         6'd3: rd_data[7:0] = rdata_q;
         6'd4: rd_data[0]   = irq_en_q;
         default: ;
      endcase
   end

   always_comb begin
      sel_ack  = 1'b0;
      sel_code = '0;
      tile_req_o = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (act_tile_q == 4'(i)) begin
            sel_ack  = tile_ack_i[i];
            sel_code = tile_rdata_i[i*8 +: 8];
            tile_req_o[i] = (state_q == S_ISSUE) || (state_q == S_VERIFY);
         end
      end
   end

   assign verify_pass = (act_op_q == OP_SET) ? (sel_code >= VTH_C) : (sel_code < VTH_C);

   always_comb begin
      state_d     = state_q;
      ack_d       = wb_take;
      dat_d       = '0;
      ctrl_op_d   = ctrl_op_q;
      ctrl_ver_d  = ctrl_ver_q;
      addr_col_d  = addr_col_q;
      addr_row_d  = addr_row_q;
      addr_tile_d = addr_tile_q;
      irq_en_d    = irq_en_q;
      done_d      = done_q;
      err_to_d    = err_to_q;
      err_ver_d   = err_ver_q;
      retries_d   = retries_q;
      rdata_d     = rdata_q;
      act_op_d    = act_op_q;
      act_ver_d   = act_ver_q;
      act_row_d   = act_row_q;
      act_col_d   = act_col_q;
      act_tile_d  = act_tile_q;
      timer_d     = timer_q;

      if (wb_take && !wbs_we_i) begin
         dat_d = rd_data;
      end

      if (wr_en) begin
         case (reg_idx)
            6'd0: begin
               ctrl_op_d  = wbs_dat_i[1:0];
               ctrl_ver_d = wbs_dat_i[3];
            end
            6'd1: begin
               addr_col_d  = wbs_dat_i[CW-1:0];
               addr_row_d  = wbs_dat_i[8 +: RW];
               addr_tile_d = wbs_dat_i[27:24];
            end
            6'd2: begin
               if (wbs_dat_i[1]) done_d    = 1'b0;
               if (wbs_dat_i[2]) err_to_d  = 1'b0;
               if (wbs_dat_i[3]) err_ver_d = 1'b0;
            end
            6'd4: irq_en_d = wbs_dat_i[0];
            default: ;
         endcase
      end

      // Sequencer updates come after register writes so hardware set beats W1C.
      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d     = 1'b0;
               err_to_d   = 1'b0;
               err_ver_d  = 1'b0;
               retries_d  = '0;
               act_op_d   = wbs_dat_i[1:0];
               act_ver_d  = wbs_dat_i[3];
               act_row_d  = addr_row_q;
               act_col_d  = addr_col_q;
               act_tile_d = addr_tile_q;
               if ({1'b0, addr_tile_q} >= NT_C) begin
                  done_d   = 1'b1;
                  err_to_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            timer_d = TW'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (sel_ack) begin
               if (act_op_q == OP_READ) begin
                  rdata_d = sel_code;
                  state_d = S_DONE;
               end else if (act_ver_q) begin
                  state_d = S_VERIFY;
               end else begin
                  state_d = S_DONE;
               end
            end else if (timer_q >= TIMEOUT_C) begin
               err_to_d = 1'b1;
               state_d  = S_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_VERIFY: begin
            timer_d = TW'(1);
            state_d = S_VWAIT;
         end
         S_VWAIT: begin
            if (sel_ack) begin
               rdata_d = sel_code;
               if (verify_pass) begin
                  state_d = S_DONE;
               end else if (retries_q < MAX_RETRY_C) begin
                  retries_d = retries_q + 4'd1;
                  state_d   = S_ISSUE;
               end else begin
                  err_ver_d = 1'b1;
                  state_d   = S_DONE;
               end
            end else if (timer_q >= TIMEOUT_C) begin
               err_to_d = 1'b1;
               state_d  = S_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q     <= S_IDLE;
         ack_q       <= 1'b0;
         dat_q       <= '0;
         ctrl_op_q   <= '0;
         ctrl_ver_q  <= 1'b0;
         addr_col_q  <= '0;
         addr_row_q  <= '0;
         addr_tile_q <= '0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         err_to_q    <= 1'b0;
         err_ver_q   <= 1'b0;
         retries_q   <= '0;
         rdata_q     <= '0;
         act_op_q    <= '0;
         act_ver_q   <= 1'b0;
         act_row_q   <= '0;
         act_col_q   <= '0;
         act_tile_q  <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         dat_q       <= dat_d;
         ctrl_op_q   <= ctrl_op_d;
         ctrl_ver_q  <= ctrl_ver_d;
         addr_col_q  <= addr_col_d;
         addr_row_q  <= addr_row_d;
         addr_tile_q <= addr_tile_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         err_to_q    <= err_to_d;
         err_ver_q   <= err_ver_d;
         retries_q   <= retries_d;
         rdata_q     <= rdata_d;
         act_op_q    <= act_op_d;
         act_ver_q   <= act_ver_d;
         act_row_q   <= act_row_d;
         act_col_q   <= act_col_d;
         act_tile_q  <= act_tile_d;
         timer_q     <= timer_d;
      end
   end

endmodule

// File: tb/tb_neuromorphic_tile_ctrl.sv
// Directed bench for neuromorphic_tile_ctrl: a behavioural tile responder answers
// requests with queued sense codes while scenario tasks check registers and pins.
module tb_neuromorphic_tile_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk;
   logic        rst_n;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;
   logic        irq_o;
   logic [3:0]  tile_req_o;
   logic [1:0]  tile_op_o;
   logic [4:0]  tile_row_o;
   logic [4:0]  tile_col_o;
   logic [3:0]  tile_ack_i;
   logic [31:0] tile_rdata_i;

   int checks = 0;
   int errors = 0;

   logic [7:0] code_q[$];
   logic [7:0] dflt_code;
   int         resp_delay;
   bit         resp_en;
   bit         spur_en;
   int         pend_cnt;
   int         pend_tile;
   logic [7:0] pend_code;
   int         req_cycles;
   int         prog_reqs;
   logic [3:0] last_req;
   logic [4:0] req_row;
   logic [4:0] req_col;
   logic [1:0] req_op;

   neuromorphic_tile_ctrl dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst_n),
      .wbs_cyc_i    (wbs_cyc_i),
      .wbs_stb_i    (wbs_stb_i),
      .wbs_we_i     (wbs_we_i),
      .wbs_sel_i    (wbs_sel_i),
      .wbs_adr_i    (wbs_adr_i),
      .wbs_dat_i    (wbs_dat_i),
      .wbs_dat_o    (wbs_dat_o),
      .wbs_ack_o    (wbs_ack_o),
      .irq_o        (irq_o),
      .tile_req_o   (tile_req_o),
      .tile_op_o    (tile_op_o),
      .tile_row_o   (tile_row_o),
      .tile_col_o   (tile_col_o),
      .tile_ack_i   (tile_ack_i),
      .tile_rdata_i (tile_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tile model: logs every request and answers after resp_delay negedges.
   initial begin
      tile_ack_i   = '0;
      tile_rdata_i = '0;
      pend_cnt     = 0;
      forever begin
         @(negedge clk);
         tile_ack_i = '0;
         if (!rst_n) pend_cnt = 0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               tile_ack_i[pend_tile] = 1'b1;
               tile_rdata_i[pend_tile*8 +: 8] = pend_code;
            end else if (pend_cnt == 2 && spur_en) begin
               tile_ack_i[(pend_tile + 1) % 4] = 1'b1;
               tile_rdata_i[((pend_tile + 1) % 4)*8 +: 8] = 8'hEE;
            end
         end
         if (tile_req_o != '0) begin
            req_cycles++;
            last_req = tile_req_o;
            req_row  = tile_row_o;
            req_col  = tile_col_o;
            req_op   = tile_op_o;
            if (tile_op_o != 2'b00) prog_reqs++;
            if (resp_en) begin
               for (int i = 0; i < 4; i++) if (tile_req_o[i]) pend_tile = i;
               pend_cnt = resp_delay;
               if (tile_op_o == 2'b00) begin
                  if (code_q.size() > 0) pend_code = code_q.pop_front();
                  else pend_code = dflt_code;
               end else begin
                  pend_code = 8'h00;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wb_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] sel);
      int n;
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_sel_i = sel; wbs_adr_i = BASE | {24'h0, off}; wbs_dat_i = data;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!wbs_ack_o && n < 4);
      if (!wbs_ack_o) begin
         checks++; errors++;
         $display("[TB] FAIL wb_write_ack off=%h got no ack expected ack", off);
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wb_read(input logic [7:0] off, output logic [31:0] data);
      int n;
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_sel_i = 4'hF; wbs_adr_i = BASE | {24'h0, off};
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!wbs_ack_o && n < 4);
      data = wbs_dat_o;
      if (!wbs_ack_o) begin
         checks++; errors++;
         data = 32'hDEAD_BEEF;
         $display("[TB] FAIL wb_read_ack off=%h got no ack expected ack", off);
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      s = 32'h1;
      for (int i = 0; i < 3000 && s[0]; i++) wb_read(8'h08, s);
      if (s[0]) begin
         checks++; errors++;
         $display("[TB] FAIL wait_idle got busy expected idle");
      end
   endtask

   task automatic clear_log();
      req_cycles = 0; prog_reqs = 0; last_req = '0;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tile_req_o !== 4'b0) begin errors++; $display("[TB] FAIL rst_req got %b expected 0000", tile_req_o); end
      checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq got %b expected 0", irq_o); end
      checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack got %b expected 0", wbs_ack_o); end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         wb_read(8'(k*4), r);
         checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL rst_reg off=%0h got %h expected 0", k*4, r); end
      end
   endtask

   task automatic test_wb_protocol();
      logic [31:0] r;
      int acks;
      wb_write(8'h00, 32'h0000_0009, 4'hF);
      wb_read(8'h00, r);
      checks++; if (r !== 32'h9) begin errors++; $display("[TB] FAIL ctrl_rw got %h expected 9", r); end
      wb_write(8'h00, 32'h0, 4'hF);
      wb_write(8'h10, 32'h1, 4'b1110);
      wb_read(8'h10, r);
      checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL sel0_ignore got %h expected 0", r); end
      wb_write(8'h14, 32'hFFFF_FFFF, 4'hF);
      wb_read(8'h14, r);
      checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL unmapped got %h expected 0", r); end
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0110;
      acks = 0;
      repeat (4) begin @(posedge clk); #1; if (wbs_ack_o) acks++; end
      wbs_adr_i = 32'h3100_0000;
      repeat (3) begin @(posedge clk); #1; if (wbs_ack_o) acks++; end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      checks++; if (acks != 0) begin errors++; $display("[TB] FAIL addr_miss got %0d acks expected 0", acks); end
   endtask

   task automatic test_read();
      logic [31:0] r;
      clear_log(); resp_delay = 4; spur_en = 1'b1; code_q.push_back(8'h5A);
      wb_write(8'h04, 32'h0200_0507, 4'hF);
      wb_read(8'h04, r);
      checks++; if (r !== 32'h0200_0507) begin errors++; $display("[TB] FAIL addr_rw got %h expected 02000507", r); end
      wb_write(8'h00, 32'h4, 4'hF);
      wait_idle();
      spur_en = 1'b0;
      checks++; if (req_cycles != 1 || last_req !== 4'b0100) begin errors++; $display("[TB] FAIL read_req got %0d/%b expected 1/0100", req_cycles, last_req); end
      checks++; if (req_row !== 5'd5 || req_col !== 5'd7 || req_op !== 2'b00) begin errors++; $display("[TB] FAIL read_cell got r%0d c%0d op%0d expected r5 c7 op0", req_row, req_col, req_op); end
      wb_read(8'h0C, r);
      checks++; if (r !== 32'h5A) begin errors++; $display("[TB] FAIL read_rdata got %h expected 5a", r); end
      wb_read(8'h08, r);
      checks++; if (r !== 32'h02) begin errors++; $display("[TB] FAIL read_status got %h expected 02", r); end
      wb_read(8'h00, r);
      checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL start_selfclear got %h expected 0", r); end
      checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL read_irq got %b expected 0", irq_o); end
   endtask

   task automatic test_back_to_back();
      logic a1, a2;
      logic [31:0] d1, d2;
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE | 32'h0C;
      @(posedge clk); #1; a1 = wbs_ack_o; d1 = wbs_dat_o;
      @(posedge clk); #1; a2 = wbs_ack_o; d2 = wbs_dat_o;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      checks++; if (a1 !== 1'b1 || d1 !== 32'h5A) begin errors++; $display("[TB] FAIL held_first got %b/%h expected 1/5a", a1, d1); end
      checks++; if (a2 !== 1'b0 || d2 !== 32'h0) begin errors++; $display("[TB] FAIL held_second got %b/%h expected 0/0", a2, d2); end
   endtask

   task automatic test_verify_retry();
      logic [31:0] r;
      clear_log(); resp_delay = 2;
      code_q.push_back(8'h40); code_q.push_back(8'h40); code_q.push_back(8'h90);
      wb_write(8'h00, 32'hD, 4'hF);
      wait_idle();
      checks++; if (req_cycles != 6 || prog_reqs != 3) begin errors++; $display("[TB] FAIL set_reqs got %0d/%0d expected 6/3", req_cycles, prog_reqs); end
      wb_read(8'h08, r);
      checks++; if (r !== 32'h22) begin errors++; $display("[TB] FAIL set_status got %h expected 22", r); end
      wb_read(8'h0C, r);
      checks++; if (r !== 32'h90) begin errors++; $display("[TB] FAIL set_rdata got %h expected 90", r); end
   endtask

   task automatic test_verify_fail();
      logic [31:0] r;
      clear_log(); resp_delay = 3; dflt_code = 8'hFF;
      wb_write(8'h10, 32'h1, 4'hF);
      wb_write(8'h00, 32'hE, 4'hF);
      wait_idle();
      checks++; if (req_cycles != 8 || prog_reqs != 4) begin errors++; $display("[TB] FAIL rst_reqs got %0d/%0d expected 8/4", req_cycles, prog_reqs); end
      wb_read(8'h08, r);
      checks++; if (r !== 32'h3A) begin errors++; $display("[TB] FAIL vfail_status got %h expected 3a", r); end
      wb_read(8'h0C, r);
      checks++; if (r !== 32'hFF) begin errors++; $display("[TB] FAIL vfail_rdata got %h expected ff", r); end
      checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL vfail_irq got %b expected 1", irq_o); end
      wb_write(8'h08, 32'hE, 4'hF);
      wb_read(8'h08, r);
      checks++; if (r !== 32'h30) begin errors++; $display("[TB] FAIL w1c_status got %h expected 30", r); end
      checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL w1c_irq got %b expected 0", irq_o); end
   endtask

   task automatic test_timeout();
      logic [31:0] r;
      clear_log(); resp_en = 1'b0;
      wb_write(8'h04, 32'h0100_0000, 4'hF);
      wb_write(8'h00, 32'h4, 4'hF);
      wb_write(8'h00, 32'h5, 4'hF);
      wb_read(8'h08, r);
      checks++; if (r !== 32'h01) begin errors++; $display("[TB] FAIL busy_start got %h expected 01", r); end
      repeat (1000) @(posedge clk);
      wb_read(8'h08, r);
      checks++; if (r !== 32'h01) begin errors++; $display("[TB] FAIL pre_timeout got %h expected 01", r); end
      wait_idle();
      wb_read(8'h08, r);
      checks++; if (r !== 32'h06) begin errors++; $display("[TB] FAIL timeout_status got %h expected 06", r); end
      checks++; if (req_cycles != 1 || req_op !== 2'b00) begin errors++; $display("[TB] FAIL timeout_reqs got %0d op%0d expected 1 op0", req_cycles, req_op); end
      checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_irq got %b expected 1", irq_o); end
      resp_en = 1'b1; clear_log();
      wb_write(8'h04, 32'h0500_0000, 4'hF);
      wb_write(8'h00, 32'h4, 4'hF);
      wb_read(8'h08, r);
      checks++; if (r !== 32'h06) begin errors++; $display("[TB] FAIL bad_tile got %h expected 06", r); end
      checks++; if (req_cycles != 0) begin errors++; $display("[TB] FAIL bad_tile_req got %0d expected 0", req_cycles); end
   endtask

   task automatic test_async_reset();
      logic [31:0] r;
      wb_write(8'h04, 32'h0200_0000, 4'hF);
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
      wbs_adr_i = BASE; wbs_dat_i = 32'h4;
      @(posedge clk); #1;
      checks++; if (tile_req_o !== 4'b0100) begin errors++; $display("[TB] FAIL issue_req got %b expected 0100", tile_req_o); end
      rst_n = 1'b0; #1;
      checks++; if (tile_req_o !== 4'b0 || wbs_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL async_req got %b/%b expected 0000/0", tile_req_o, wbs_ack_o); end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      code_q.delete(); resp_delay = 20; code_q.push_back(8'h33);
      wb_write(8'h10, 32'h1, 4'hF);
      wb_write(8'h04, 32'h0100_0309, 4'hF);
      wb_write(8'h00, 32'h4, 4'hF);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0; #1;
      checks++; if (tile_req_o !== 4'b0 || irq_o !== 1'b0) begin errors++; $display("[TB] FAIL wait_reset got %b/%b expected 0000/0", tile_req_o, irq_o); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wb_read(8'h08, r);
      checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL rst_status got %h expected 0", r); end
      wb_read(8'h04, r);
      checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr got %h expected 0", r); end
      wb_read(8'h10, r);
      checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL rst_irqen got %h expected 0", r); end
      clear_log(); code_q.delete(); code_q.push_back(8'h33); resp_delay = 3;
      wb_write(8'h04, 32'h0100_0309, 4'hF);
      wb_write(8'h00, 32'h4, 4'hF);
      wait_idle();
      wb_read(8'h0C, r);
      checks++; if (r !== 32'h33) begin errors++; $display("[TB] FAIL post_rdata got %h expected 33", r); end
      wb_read(8'h08, r);
      checks++; if (r !== 32'h02) begin errors++; $display("[TB] FAIL post_status got %h expected 02", r); end
      checks++; if (last_req !== 4'b0010 || req_row !== 5'd3 || req_col !== 5'd9) begin errors++; $display("[TB] FAIL post_req got %b r%0d c%0d expected 0010 r3 c9", last_req, req_row, req_col); end
   endtask

   initial begin
      rst_n = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
      dflt_code = 8'h00; resp_delay = 4; resp_en = 1'b1; spur_en = 1'b0;
      pend_tile = 0; pend_code = '0; req_row = '0; req_col = '0; req_op = '0;
      clear_log();
      test_reset();
      test_wb_protocol();
      test_read();
      test_back_to_back();
      test_verify_retry();
      test_verify_fail();
      test_timeout();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuromorphic_tile_ctrl.md
Name: neuromorphic_tile_ctrl

Overview:
- Parametrised Wishbone slave fronting NUM_TILES ReRAM crossbar tiles (ROWS x COLS each) in the user project area; successor to the single-tile Neuromorphic wrapper.
- Sequences single-cell READ / SET / RESET operations to a selected tile over a req/ack handshake, with optional program-verify retry, per-operation timeout, status register and done interrupt.

Parameters:
- NUM_TILES, 4, number of attached tiles (1..16)
- ROWS, 32, rows per tile; RW = clog2(ROWS)
- COLS, 32, columns per tile; CW = clog2(COLS)
- BASE_ADDR, 32'h3000_0000, Wishbone base; block decodes adr[31:8] == BASE_ADDR[31:8]
- MAX_RETRY, 3, max program re-attempts after failed verify (0..15)
- TIMEOUT, 1023, cycles waited for tile_ack before error
- VTH, 128, 8-bit sense threshold: code >= VTH means SET state

Ports:
- wb_clk_i in 1 single clock
- wb_rst_i in 1 reset, asynchronous, active-low
- wbs_cyc_i in 1 Wishbone cycle
- wbs_stb_i in 1 Wishbone strobe
- wbs_we_i in 1 write enable
- wbs_sel_i in 4 byte selects (byte 0 only honoured)
- wbs_adr_i in 32 address
- wbs_dat_i in 32 write data
- wbs_dat_o out 32 read data
- wbs_ack_o out 1 acknowledge
- irq_o out 1 level interrupt = STATUS.done & IRQ_EN[0]
- tile_req_o out NUM_TILES one-hot request, only selected tile
- tile_op_o out 2 00 READ, 01 SET, 10 RESET
- tile_row_o out RW row
- tile_col_o out CW column
- tile_ack_i in NUM_TILES per-tile completion pulse
- tile_rdata_i in NUM_TILES*8 per-tile 8-bit sense code, valid with ack on READ

Behaviour:
- Register map (adr[7:2]): 0x00 CTRL rw [1:0] op, [2] start (self-clearing, reads 0), [3] verify_en; 0x04 ADDR rw [CW-1:0] col, [15:8] row, [27:24] tile; 0x08 STATUS [0] busy (ro), [1] done, [2] err_timeout, [3] err_verify (W1C), [7:4] retries used (ro); 0x0C RDATA ro [7:0] last sense code; 0x10 IRQ_EN rw [0]. Unmapped offsets read 0, writes ignored.
- Wishbone: ack asserted exactly one cycle after cyc&stb&address match, one-cycle pulse, deasserted the following cycle even if stb held; no ack for non-matching address. wbs_dat_o valid with ack, else 0.
- Reset: all outputs 0, all registers 0, FSM IDLE.
- FSM: IDLE -> ISSUE on start write while not busy; start while busy ignored, no status change. Start also clears done/err bits and retries. Tile index >= NUM_TILES: done=1, err_timeout=1 in one cycle, no request.
- ISSUE: drive tile_req_o[tile] with op/row/col for one cycle -> WAIT. Row/col/op held stable until DONE.
- WAIT: on tile_ack_i[tile]: READ -> latch code into RDATA -> DONE; SET/RESET -> VERIFY if verify_en else DONE. Timer counts from ISSUE; reaching TIMEOUT cycles without ack -> err_timeout, DONE. Acks from non-selected tiles ignored.
- VERIFY: issue READ (one-cycle req), wait ack (same timeout). Pass: SET needs code >= VTH, RESET needs code < VTH; latch code into RDATA. Pass -> DONE. Fail and retries < MAX_RETRY -> retries+1, back to ISSUE with original op. Fail at MAX_RETRY -> err_verify, DONE.
- DONE: set done, busy=0, -> IDLE next cycle. busy=1 in every state except IDLE.
- Ack and timeout same cycle: ack wins.
- Async reset mid-operation aborts immediately; tile_req_o deasserts with reset.

Test Plan:
- Reset, read all registers -> all 0, irq_o 0, tile_req_o 0.
- ADDR tile2 row5 col7, CTRL op=READ start; tile2 acks after 4 cycles with code 0x5A -> tile_req_o=4'b0100 one cycle, RDATA=0x5A, STATUS=0x02.
- SET with verify_en, model returns 0x40,0x40,0x90 -> two retries, STATUS done=1 retries=2 no error, RDATA=0x90.
- RESET with verify_en, model always returns 0xFF, MAX_RETRY=3 -> 4 program attempts, err_verify=1, retries=3; IRQ_EN=1 -> irq_o=1 until STATUS W1C 0x0E clears it.
- No ack: after 1023 cycles err_timeout=1, done=1; start while busy and tile index 5 (NUM_TILES=4) -> ignored and immediate err_timeout respectively.
- Assert wb_rst_i low during WAIT -> tile_req_o, busy, STATUS all 0 asynchronously; subsequent READ completes normally.
